npu_fetch_ctrl: RTL and testbench

- Instruction fetch sequencer for the NPU core.
- Acts as an AXI4-Lite read master in front of the 1 MB instruction ROM.
- Issues word-aligned sequential reads from a programmable PC and buffers returned words in a small prefetch FIFO.
- Presents instructions to the decoder on a valid/ready stream, with PC redirect (branch) and stop support.

---
 rtl/npu_fetch_pkg.sv | 17 +
 rtl/npu_fetch_fifo.sv | 60 ++++++
 rtl/npu_fetch_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_npu_fetch_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_fetch_pkg.sv
// Shared types and constants for the NPU instruction fetch sequencer.
// Optional performance counters are enabled with the NPU_FETCH_PERF_EN macro.
package npu_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DRAIN,
    ST_HALT
  } fetch_state_e;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [2:0]  ARPROT_INST = 3'b100;
  localparam int unsigned PC_STEP     = 4;

endpackage

// File: rtl/npu_fetch_fifo.sv
// Prefetch FIFO: power-of-2 depth, combinational head, single-cycle flush.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module npu_fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (count_o == '0);
  assign full_o  = (count_o == DEPTH_C);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign rdata_o = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/npu_fetch_ctrl.sv
// Instruction fetch sequencer: single-outstanding AXI4-Lite read master feeding a
// prefetch FIFO. Define NPU_FETCH_PERF_EN to add saturating performance counters.
module npu_fetch_ctrl
  import npu_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_pc,
  input  logic                  stop,
  input  logic                  redir_valid,
  input  logic [ADDR_WIDTH-1:0] redir_pc,
  output logic                  busy,
  output logic                  err,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [2:0]            m_arprot,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready
`ifdef NPU_FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]      DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, rd_pc_q, rd_pc_d, pend_pc_q, pend_pc_d;
  logic                  err_q, err_d, pend_q, pend_d, stop_q, stop_d;
  logic                  kill, redir_take, push, pop, fifo_empty, fifo_full;
  logic [ADDR_WIDTH-1:0] redir_aligned;
  logic [CNT_W-1:0]      fifo_count;
  logic [DATA_WIDTH+ADDR_WIDTH-1:0] fifo_head;

  assign kill          = (state_q != ST_IDLE) && (stop || redir_valid);
  assign redir_take    = kill && !stop;
  assign redir_aligned = redir_pc & ALIGN_MASK;
  assign pop           = inst_valid && inst_ready;

  // pend_q marks an AR that must still complete at the old address after a flush;
  // its eventual beat is dropped in DRAIN. stop_q makes a drain end in IDLE.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    rd_pc_d   = rd_pc_q;
    err_d     = err_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    stop_d    = stop_q;
    push      = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          pc_d    = start_pc & ALIGN_MASK;
          err_d   = 1'b0;
          pend_d  = 1'b0;
          stop_d  = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        m_arvalid = pend_q || (fifo_count < DEPTH_C);
        if (m_arvalid && m_arready) begin
          rd_pc_d = pc_q;
          if (pend_q || kill) begin
            state_d = ST_DRAIN;
            pend_d  = 1'b0;
            stop_d  = stop_q || stop;
            if (redir_take)  pc_d = redir_aligned;
            else if (pend_q) pc_d = pend_pc_q;
          end else begin
            state_d = ST_WAIT;
          end
        end else if (kill) begin
          if (m_arvalid) begin
            pend_d = 1'b1;
            stop_d = stop_q || stop;
            if (redir_take)   pend_pc_d = redir_aligned;
            else if (!pend_q) pend_pc_d = pc_q;
          end else if (stop) begin
            state_d = ST_IDLE;
          end else begin
            pc_d = redir_aligned;
          end
        end
      end
      ST_WAIT: begin
        m_rready = 1'b1;
        if (kill) begin
          stop_d = stop;
          if (redir_take) pc_d = redir_aligned;
          if (m_rvalid) state_d = stop ? ST_IDLE : ST_ISSUE;
          else          state_d = ST_DRAIN;
        end else if (m_rvalid) begin
          if (m_rresp == RESP_OKAY) begin
            push    = 1'b1;
            pc_d    = pc_q + ADDR_WIDTH'(PC_STEP);
            state_d = ST_ISSUE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_HALT;
          end
        end
      end
      ST_DRAIN: begin
        m_rready = 1'b1;
        if (redir_take) pc_d = redir_aligned;
        if (stop)       stop_d = 1'b1;
        if (m_rvalid)   state_d = (stop_q || stop) ? ST_IDLE : ST_ISSUE;
      end
      ST_HALT: begin
        if (kill) begin
          if (stop) begin
            state_d = ST_IDLE;
          end else begin
            pc_d    = redir_aligned;
            state_d = ST_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      rd_pc_q   <= '0;
      pend_pc_q <= '0;
      err_q     <= 1'b0;
      pend_q    <= 1'b0;
      stop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      rd_pc_q   <= rd_pc_d;
      pend_pc_q <= pend_pc_d;
      err_q     <= err_d;
      pend_q    <= pend_d;
      stop_q    <= stop_d;
    end
  end

  npu_fetch_fifo #(
    .WIDTH (DATA_WIDTH + ADDR_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (kill),
    .push_i  (push),
    .wdata_i ({m_rdata, rd_pc_q}),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  // Head is masked while empty so the decoder sees zeros instead of stale RAM.
  assign inst_valid = !fifo_empty;
  assign inst_data  = inst_valid ? fifo_head[ADDR_WIDTH +: DATA_WIDTH] : '0;
  assign inst_pc    = inst_valid ? fifo_head[ADDR_WIDTH-1:0] : '0;
  assign m_araddr   = pc_q;
  assign m_arprot   = ARPROT_INST;
  assign busy       = (state_q != ST_IDLE);
  assign err        = err_q;

`ifdef NPU_FETCH_PERF_EN
  logic start_take;
  assign start_take = (state_q == ST_IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else if (start_take) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (push && perf_fetch_cnt != '1) perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
      if (state_q == ST_ISSUE && !pend_q && fifo_full && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (redir_take && perf_flush_cnt != '1) perf_flush_cnt <= perf_flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_npu_fetch_ctrl.sv
// Directed bench for npu_fetch_ctrl: reactive AXI ROM slave plus an instruction
// scoreboard (expected PCs queued at stimulus time, compared on every pop).
module tb_npu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, redir_valid = 1'b0, inst_ready = 1'b0;
  logic [31:0] start_pc = '0, redir_pc = '0;
  logic        busy, err, inst_valid, m_arvalid, m_rready;
  logic [31:0] inst_data, inst_pc, m_araddr;
  logic [2:0]  m_arprot;
  logic        m_arready = 1'b1, m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rresp = 2'b00;

  int          vectors = 0, miscompares = 0, cyc = 0, rd_lat = 0;
  logic [31:0] err_addr = 32'hFFFF_FFF1;
  logic [31:0] exp_pc_q[$];
  logic [31:0] ar_q[$];
  int          ar_cyc_q[$];
  logic        ar_fire = 1'b0, r_fire = 1'b0, slv_busy = 1'b0;
  logic [31:0] ar_fire_addr = '0, slv_addr = '0;
  int          slv_cnt = 0;

  always #5 clk = ~clk;

  npu_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc), .stop(stop),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .busy(busy), .err(err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_sb(input string tag, input int bound);
    for (int i = 0; i < bound && exp_pc_q.size() != 0; i++) tick(1);
    check(tag, exp_pc_q.size(), 0);
  endtask

  task automatic wait_ar(input string tag, input int n, input int bound);
    for (int i = 0; i < bound && ar_q.size() < n; i++) tick(1);
    check(tag, ar_q.size(), n);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    for (int i = 0; i < bound && busy; i++) tick(1);
    check(tag, busy, 0);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
  endtask

  // Mid-cycle observation: inputs change only just after posedge, so values seen
  // here are exactly what the next posedge samples.
  always @(negedge clk) begin
    ar_fire      = m_arvalid && m_arready;
    r_fire       = m_rvalid && m_rready;
    ar_fire_addr = m_araddr;
    if (rst_n && ar_fire) begin
      ar_q.push_back(m_araddr);
      ar_cyc_q.push_back(cyc);
    end
    if (rst_n && inst_valid && inst_ready) begin
      vectors++;
      assert (exp_pc_q.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_inst: observed pc 0x%08h expected no instruction", inst_pc);
      end
      if (exp_pc_q.size() != 0) begin
        logic [31:0] e;
        e = exp_pc_q.pop_front();
        check("inst_pc", inst_pc, e);
        check("inst_data", inst_data, rom_word(e));
      end
      $display("inst pc=0x%08h data=0x%08h", inst_pc, inst_data);
    end
  end

  // ROM slave: one read at a time, rd_lat idle cycles before R valid.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (!rst_n) begin
      m_rvalid = 1'b0;
      slv_busy = 1'b0;
    end else begin
      if (r_fire) m_rvalid = 1'b0;
      if (ar_fire) begin
        slv_busy = 1'b1;
        slv_addr = ar_fire_addr;
        slv_cnt  = rd_lat;
      end
      if (slv_busy) begin
        if (slv_cnt == 0) begin
          m_rvalid = 1'b1;
          m_rdata  = rom_word(slv_addr);
          m_rresp  = (slv_addr == err_addr) ? 2'b10 : 2'b00;
          slv_busy = 1'b0;
        end else begin
          slv_cnt--;
        end
      end
    end
  end

  initial begin
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_arvalid", m_arvalid, 0);
    check("rst_rready", m_rready, 0);
    check("rst_araddr", m_araddr, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("arprot", {29'd0, m_arprot}, 32'h4);

    // Sequential fetch
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_pc_q.push_back(32'h100 + 32'(4 * i));
    start_pc = 32'h100;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_sb("seq_drain", 60);
    inst_ready = 1'b0;
    check("seq_first_ar", ar_q[0], 32'h100);
    for (int i = 1; i < 4; i++) check("seq_ar_gap", 32'(ar_cyc_q[i] - ar_cyc_q[i-1] >= 2), 1);
    do_stop();
    wait_idle("seq_stop_idle", 20);
    check("seq_flush_valid", inst_valid, 0);

    // Backpressure
    ar_q.delete();
    ar_cyc_q.delete();
    start_pc = 32'h200;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(30);
    check("bp_ar_count", ar_q.size(), 4);
    check("bp_last_ar", ar_q[3], 32'h20C);
    check("bp_arvalid_low", m_arvalid, 0);
    check("bp_inst_valid", inst_valid, 1);
    exp_pc_q.push_back(32'h200);
    inst_ready = 1'b1;
    tick(1);
    inst_ready = 1'b0;
    tick(10);
    check("bp_ar_after_pop", ar_q.size(), 5);
    check("bp_refill_addr", ar_q[4], 32'h210);
    check("bp_arvalid_full", m_arvalid, 0);
    do_stop();
    wait_idle("bp_stop_idle", 20);

    // Redirect while a read is outstanding
    ar_q.delete();
    rd_lat = 5;
    inst_ready = 1'b1;
    exp_pc_q.push_back(32'h100);
    exp_pc_q.push_back(32'h104);
    start_pc = 32'h100;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_ar("rw_ar_108", 3, 60);
    check("rw_addr_108", ar_q[2], 32'h108);
    check("rw_in_wait", m_rready, 1);
    check("rw_sb_before", exp_pc_q.size(), 0);
    exp_pc_q.push_back(32'h2000);
    exp_pc_q.push_back(32'h2004);
    redir_pc = 32'h2002;
    redir_valid = 1'b1;
    tick(1);
    redir_valid = 1'b0;
    check("rw_flush_valid", inst_valid, 0);
    wait_sb("rw_drain", 80);
    inst_ready = 1'b0;
    check("rw_next_ar", ar_q[3], 32'h2000);
    do_stop();
    wait_idle("rw_stop_idle", 30);

    // Redirect while AR is stalled
    ar_q.delete();
    rd_lat = 0;
    m_arready = 1'b0;
    inst_ready = 1'b1;
    start_pc = 32'h300;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    check("st_arvalid", m_arvalid, 1);
    check("st_araddr", m_araddr, 32'h300);
    redir_pc = 32'h400;
    redir_valid = 1'b1;
    tick(1);
    redir_valid = 1'b0;
    check("st_hold_valid", m_arvalid, 1);
    check("st_hold_addr", m_araddr, 32'h300);
    exp_pc_q.push_back(32'h400);
    exp_pc_q.push_back(32'h404);
    m_arready = 1'b1;
    wait_sb("st_drain", 40);
    inst_ready = 1'b0;
    check("st_old_ar", ar_q[0], 32'h300);
    check("st_new_ar", ar_q[1], 32'h400);
    do_stop();
    wait_idle("st_stop_idle", 20);

    // Error response
    ar_q.delete();
    err_addr = 32'h10;
    start_pc = 32'h4;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(30);
    check("er_err", err, 1);
    check("er_busy", busy, 1);
    check("er_ar_count", ar_q.size(), 4);
    check("er_last_ar", ar_q[3], 32'h10);
    check("er_arvalid", m_arvalid, 0);
    for (int i = 1; i < 4; i++) exp_pc_q.push_back(32'(4 * i));
    inst_ready = 1'b1;
    wait_sb("er_drain", 20);
    tick(3);
    check("er_empty", inst_valid, 0);
    check("er_no_more_ar", ar_q.size(), 4);
    do_stop();
    check("er_halt_stop", busy, 0);
    check("er_sticky", err, 1);
    err_addr = 32'hFFFF_FFF1;

    // Wrap and stop during WAIT
    ar_q.delete();
    rd_lat = 3;
    exp_pc_q.push_back(32'hFFFF_FFFC);
    start_pc = 32'hFFFF_FFFC;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("wr_err_cleared", err, 0);
    wait_ar("wr_ar_count", 2, 40);
    check("wr_wrap_addr", ar_q[1], 32'h0);
    check("wr_in_wait", m_rready, 1);
    do_stop();
    check("wr_busy_drain", busy, 1);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (m_rvalid && m_rready) begin
          seen = 1'b1;
          check("wr_busy_at_beat", busy, 1);
        end
      end
      tick(1);
      check("wr_beat_seen", seen, 1);
      check("wr_busy_after", busy, 0);
    end
    tick(3);
    check("wr_sb_empty", exp_pc_q.size(), 0);
    check("wr_no_inst", inst_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected summary");
    $fatal(1, "timeout");
  end

endmodule
